// File: rtl/rf_write_arbiter_if.sv
// Write-port bundle between the requesters/clear control and the register-file
// write arbiter: requests, grants, clear handshake and the registered write port.
interface rf_write_arbiter_if #(
  parameter int W = 7
);
  logic         clr_start;
  logic         clr_busy;
  logic [2:0]   req;
  logic [2:0]   gnt;
  logic [3:0]   rd0;
  logic [3:0]   rd1;
  logic [3:0]   rd2;
  logic [W:0]   data0;
  logic [W:0]   data1;
  logic [W:0]   data2;
  logic [3:0]   rf_rd;
  logic [W:0]   rf_data;
  logic         rf_ena;

  modport master (
    output clr_start, req, rd0, rd1, rd2, data0, data1, data2,
    input  clr_busy, gnt, rf_rd, rf_data, rf_ena
  );

  modport slave (
    input  clr_start, req, rd0, rd1, rd2, data0, data1, data2,
    output clr_busy, gnt, rf_rd, rf_data, rf_ena
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a hardware
// clear sequence that zeroes r1..rN because the register file has no reset.
module rf_write_arbiter #(
  parameter int W = 7,
  parameter int N = 15
) (
  input  logic             clk,
  input  logic             reset,
  rf_write_arbiter_if.slave bus
);

  localparam logic [3:0] LAST_L = 4'(N);

  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t     state_r, state_nxt_s;
  logic [1:0] ptr_r, ptr_nxt_s;
  logic [3:0] cnt_r, cnt_nxt_s;
  logic [3:0] rf_rd_r, rf_rd_nxt_s;
  logic [W:0] rf_data_r, rf_data_nxt_s;
  logic       rf_ena_r, rf_ena_nxt_s;
  logic       busy_r, busy_nxt_s;

  logic [2:0] gnt_s;
  logic [3:0] sel_rd_s;
  logic [W:0] sel_data_s;
  logic [1:0] win_ptr_s;

  // Rotating-priority grant; suppressed in reset and while clearing
  always_comb begin
    gnt_s = 3'b000;
    if (reset) begin
      gnt_s = 3'b000;
    end else if (state_r == ST_ARB) begin
      case (ptr_r)
        2'd0: begin
          if (bus.req[0])      gnt_s = 3'b001;
          else if (bus.req[1]) gnt_s = 3'b010;
          else if (bus.req[2]) gnt_s = 3'b100;
          else                 gnt_s = 3'b000;
        end
        2'd1: begin
          if (bus.req[1])      gnt_s = 3'b010;
          else if (bus.req[2]) gnt_s = 3'b100;
          else if (bus.req[0]) gnt_s = 3'b001;
          else                 gnt_s = 3'b000;
        end
        2'd2: begin
          if (bus.req[2])      gnt_s = 3'b100;
          else if (bus.req[0]) gnt_s = 3'b001;
          else if (bus.req[1]) gnt_s = 3'b010;
          else                 gnt_s = 3'b000;
        end
        default: gnt_s = 3'b000;
      endcase
    end else begin
      gnt_s = 3'b000;
    end
  end

  // Winner's address/data and the pointer value that follows it
  always_comb begin
    sel_rd_s   = 4'd0;
    sel_data_s = {(W+1){1'b0}};
    win_ptr_s  = ptr_r;
    case (gnt_s)
      3'b001: begin
        sel_rd_s   = bus.rd0;
        sel_data_s = bus.data0;
        win_ptr_s  = 2'd1;
      end
      3'b010: begin
        sel_rd_s   = bus.rd1;
        sel_data_s = bus.data1;
        win_ptr_s  = 2'd2;
      end
      3'b100: begin
        sel_rd_s   = bus.rd2;
        sel_data_s = bus.data2;
        win_ptr_s  = 2'd0;
      end
      default: begin
        sel_rd_s   = 4'd0;
        sel_data_s = {(W+1){1'b0}};
        win_ptr_s  = ptr_r;
      end
    endcase
  end

  // Next-state and next-output computation for both states
  always_comb begin
    state_nxt_s   = state_r;
    ptr_nxt_s     = ptr_r;
    cnt_nxt_s     = cnt_r;
    rf_rd_nxt_s   = rf_rd_r;
    rf_data_nxt_s = rf_data_r;
    rf_ena_nxt_s  = 1'b0;
    busy_nxt_s    = busy_r;
    case (state_r)
      ST_ARB: begin
        if (gnt_s != 3'b000) begin
          rf_rd_nxt_s   = sel_rd_s;
          rf_data_nxt_s = sel_data_s;
          // A write to r0 is consumed but never reaches the register file
          rf_ena_nxt_s  = (sel_rd_s != 4'd0);
          ptr_nxt_s     = win_ptr_s;
        end else begin
          rf_ena_nxt_s  = 1'b0;
        end
        if (bus.clr_start) begin
          state_nxt_s = ST_CLEAR;
          busy_nxt_s  = 1'b1;
          cnt_nxt_s   = 4'd1;
        end else begin
          state_nxt_s = ST_ARB;
          busy_nxt_s  = 1'b0;
        end
      end
      ST_CLEAR: begin
        rf_ena_nxt_s  = 1'b1;
        rf_rd_nxt_s   = cnt_r;
        rf_data_nxt_s = {(W+1){1'b0}};
        if (cnt_r >= LAST_L) begin
          state_nxt_s = ST_ARB;
          busy_nxt_s  = 1'b0;
          cnt_nxt_s   = 4'd1;
        end else begin
          state_nxt_s = ST_CLEAR;
          busy_nxt_s  = 1'b1;
          cnt_nxt_s   = cnt_r + 4'd1;
        end
      end
      default: begin
        state_nxt_s  = ST_ARB;
        busy_nxt_s   = 1'b0;
        cnt_nxt_s    = 4'd1;
        rf_ena_nxt_s = 1'b0;
      end
    endcase
  end

  // State and registered write-port outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_ARB;
      ptr_r     <= 2'd0;
      cnt_r     <= 4'd1;
      rf_rd_r   <= 4'd0;
      rf_data_r <= {(W+1){1'b0}};
      rf_ena_r  <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      ptr_r     <= ptr_nxt_s;
      cnt_r     <= cnt_nxt_s;
      rf_rd_r   <= rf_rd_nxt_s;
      rf_data_r <= rf_data_nxt_s;
      rf_ena_r  <= rf_ena_nxt_s;
      busy_r    <= busy_nxt_s;
    end
  end

  assign bus.gnt      = gnt_s;
  assign bus.rf_rd    = rf_rd_r;
  assign bus.rf_data  = rf_data_r;
  assign bus.rf_ena   = rf_ena_r;
  assign bus.clr_busy = busy_r;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: a queue-based behavioural model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_rf_write_arbiter;

  localparam int W = 7;
  localparam int N = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic       clr_start;
  logic [2:0] req;
  logic [3:0] rd_v   [3];
  logic [W:0] data_v [3];

  int n_total = 0;
  int n_pass  = 0;

  rf_write_arbiter_if #(.W(W)) bus ();

  assign bus.clr_start = clr_start;
  assign bus.req       = req;
  assign bus.rd0       = rd_v[0];
  assign bus.rd1       = rd_v[1];
  assign bus.rd2       = rd_v[2];
  assign bus.data0     = data_v[0];
  assign bus.data1     = data_v[1];
  assign bus.data2     = data_v[2];

  rf_write_arbiter #(.W(W), .N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: pointer, a queue of pending clear addresses, expected write port
  int         m_ptr = 0;
  int         clr_q[$];
  logic       e_ena, e_busy;
  logic [3:0] e_rd;
  logic [W:0] e_data;
  bit         mdl_on = 1'b0;

  function automatic logic [2:0] mdl_gnt(input logic rst, input logic [2:0] r,
                                         input int p, input int qsz);
    logic [2:0] one;
    one = 3'b001;
    if (rst || qsz > 0) return 3'b000;
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (p + k) % 3;
      if (r[i]) return one << i;
    end
    return 3'b000;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_ptr = 0;
      clr_q.delete();
      e_ena = 1'b0; e_rd = 4'd0; e_data = '0; e_busy = 1'b0;
      mdl_on = 1'b1;
    end else if (mdl_on) begin
      if (clr_q.size() > 0) begin
        e_ena  = 1'b1;
        e_rd   = 4'(clr_q.pop_front());
        e_data = '0;
        e_busy = (clr_q.size() > 0);
      end else begin
        logic [2:0] g;
        g = mdl_gnt(1'b0, req, m_ptr, 0);
        e_ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
          if (g[i]) begin
            e_rd   = rd_v[i];
            e_data = data_v[i];
            e_ena  = (rd_v[i] != 4'd0);
            m_ptr  = (i + 1) % 3;
          end
        end
        if (clr_start) begin
          for (int a = 1; a <= N; a++) clr_q.push_back(a);
          e_busy = 1'b1;
        end else begin
          e_busy = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mdl_on) begin
      chk("mdl_gnt",  32'(bus.gnt),      32'(mdl_gnt(reset, req, m_ptr, clr_q.size())));
      chk("mdl_ena",  32'(bus.rf_ena),   32'(e_ena));
      chk("mdl_rd",   32'(bus.rf_rd),    32'(e_rd));
      chk("mdl_data", 32'(bus.rf_data),  32'(e_data));
      chk("mdl_busy", 32'(bus.clr_busy), 32'(e_busy));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] exp_g  [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
  logic [3:0] exp_rd [3] = '{4'd1, 4'd2, 4'd3};

  initial begin
    reset     = 1'b1;
    clr_start = 1'b0;
    req       = 3'b111;
    rd_v      = '{4'd1, 4'd2, 4'd3};
    data_v    = '{8'h11, 8'h22, 8'h33};
    #2;
    chk("gnt_in_reset", 32'(bus.gnt), 32'd0);
    cyc(); cyc();
    chk("rst_ena",  32'(bus.rf_ena),   32'd0);
    chk("rst_rd",   32'(bus.rf_rd),    32'd0);
    chk("rst_data", 32'(bus.rf_data),  32'd0);
    chk("rst_busy", 32'(bus.clr_busy), 32'd0);

    // All three requesting: strict rotation
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_gnt", 32'(bus.gnt), 32'(exp_g[i]));
      if (i > 0) begin
        chk("rr_rd",  32'(bus.rf_rd),  32'(exp_rd[(i-1)%3]));
        chk("rr_ena", 32'(bus.rf_ena), 32'd1);
      end
      cyc();
    end
    chk("rr_rd_last", 32'(bus.rf_rd), 32'd3);
    chk("rr_data_last", 32'(bus.rf_data), 32'h33);
    req = 3'b000;
    cyc();

    // Lone requester gets back-to-back grants
    req = 3'b010; rd_v[1] = 4'd5; data_v[1] = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("solo_gnt", 32'(bus.gnt), 32'b010);
      if (i > 0) begin
        chk("solo_rd",   32'(bus.rf_rd),   32'd5);
        chk("solo_data", 32'(bus.rf_data), 32'hA5);
        chk("solo_ena",  32'(bus.rf_ena),  32'd1);
      end
      cyc();
    end
    chk("solo_ena_last", 32'(bus.rf_ena), 32'd1);
    req = 3'b000;
    cyc();
    chk("idle_ena",  32'(bus.rf_ena),  32'd0);
    chk("idle_hold", 32'(bus.rf_rd),   32'd5);

    // Write to r0 is discarded but advances the pointer
    req = 3'b001; rd_v[0] = 4'd0;
    #1;
    chk("r0_gnt", 32'(bus.gnt), 32'b001);
    cyc();
    chk("r0_ena", 32'(bus.rf_ena), 32'd0);
    req = 3'b011; rd_v[0] = 4'd1;
    #1;
    chk("r0_ptr_gnt", 32'(bus.gnt), 32'b010);
    cyc();
    chk("r0_next_ena", 32'(bus.rf_ena), 32'd1);
    chk("r0_next_rd",  32'(bus.rf_rd),  32'd5);
    req = 3'b000;
    cyc();

    // Clear with a concurrent grant, and an ignored clr_start mid-clear
    req = 3'b100; clr_start = 1'b1;
    #1;
    chk("clr_same_gnt", 32'(bus.gnt), 32'b100);
    cyc();
    clr_start = 1'b0;
    chk("clr_first_rd", 32'(bus.rf_rd), 32'd3);
    for (int c = 1; c <= N; c++) begin
      clr_start = (c == 5);
      #1;
      chk("clr_gnt",  32'(bus.gnt),      32'd0);
      chk("clr_busy", 32'(bus.clr_busy), 32'd1);
      if (c > 1) begin
        chk("clr_rd",   32'(bus.rf_rd),   32'(c - 1));
        chk("clr_data", 32'(bus.rf_data), 32'd0);
        chk("clr_ena",  32'(bus.rf_ena),  32'd1);
      end
      cyc();
    end
    clr_start = 1'b0;
    #1;
    chk("clr_done_busy", 32'(bus.clr_busy), 32'd0);
    chk("clr_last_rd",   32'(bus.rf_rd),    32'd15);
    chk("clr_last_ena",  32'(bus.rf_ena),   32'd1);
    chk("clr_after_gnt", 32'(bus.gnt),      32'b100);
    cyc();
    chk("clr_after_rd", 32'(bus.rf_rd), 32'd3);
    req = 3'b000;
    cyc();

    // Reset in the middle of a clear
    req = 3'b001; clr_start = 1'b1;
    cyc();
    clr_start = 1'b0; req = 3'b011;
    for (int c = 1; c <= 6; c++) cyc();
    reset = 1'b1;
    #1;
    chk("rstclr_busy", 32'(bus.clr_busy), 32'd1);
    chk("rstclr_gnt",  32'(bus.gnt),      32'd0);
    cyc();
    reset = 1'b0;
    #1;
    chk("rstclr_busy_after", 32'(bus.clr_busy), 32'd0);
    chk("rstclr_ena_after",  32'(bus.rf_ena),   32'd0);
    chk("rstclr_gnt_after",  32'(bus.gnt),      32'b001);
    cyc();
    chk("rstclr_rd", 32'(bus.rf_rd), 32'd1);
    req = 3'b000;
    cyc(); cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
